prog_uart_rx: RTL

Serial byte receiver and receive FIFO that sits directly upstream of the RAM UART programmer. It samples the programming RX pin (8N1, LSB first) and buffers completed bytes in a small FIFO. It presents them through a poll-style read port that returns all-ones when empty, so the programmer state machine can hold its read enable high and treat any non-all-ones word as a fresh byte.

---
 rtl/prog_uart_pkg.sv | 18 +
 rtl/prog_uart_fifo.sv | 58 +++++
 rtl/prog_uart_rx.sv | 134 +++++++++++++
 3 files changed

// File: rtl/prog_uart_pkg.sv
// Shared types and helpers for the programming-port UART receiver.
package prog_uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

    localparam logic [31:0] UART_EMPTY_WORD = 32'hFFFF_FFFF;

    function automatic int baud_div(input int clk, input int baud);
        return clk / baud;
    endfunction

endpackage

// File: rtl/prog_uart_fifo.sv
// Byte FIFO for received UART data; a pop on empty is ignored, a push on full
// lands only when a pop frees the slot on the same edge.
module prog_uart_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [7:0]               wr_data_i,
    input  logic                     pop_i,
    output logic [7:0]               rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty_o   = (count == '0);
    assign full_o    = (count == FULL_COUNT);
    assign do_pop    = pop_i && !empty_o;
    assign do_push   = push_i && (!full_o || do_pop);
    assign rd_data_o = mem[rd_ptr];
    assign level_o   = count;

    // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/prog_uart_rx.sv
// 8N1 receiver feeding a byte FIFO with a poll-style read port that returns
// all-ones when empty, for the RAM UART programmer.
module prog_uart_rx
    import prog_uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          rx_i,
    input  logic                          rd_en_i,
    output logic [31:0]                   rd_data_o,
    input  logic                          clr_i,
    output logic                          overflow_o,
    output logic                          frame_err_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_START = START;
    localparam logic [2:0] S_DATA  = DATA;
    localparam logic [2:0] S_STOP  = STOP;
    localparam logic [2:0] S_BREAK = BREAK;

    logic [1:0]    sync_q;
    logic          rxs;
    logic [2:0]    state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          expire;
    logic          push;
    logic          fe_set;
    logic          ovf_set;
    logic [7:0]    head;
    logic          fifo_full;
    logic          fifo_empty;

    // Reset to the idle level so leaving reset never looks like a start edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], rx_i};
    end
    assign rxs    = sync_q[1];
    assign expire = (cnt_q == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (!rxs) begin
                    state_q <= S_START;
                    cnt_q   <= HALF_LOAD;
                end
                S_START: if (!expire) begin
                    cnt_q <= cnt_q - 1'b1;
                end else if (rxs) begin
                    state_q <= S_IDLE;
                end else begin
                    state_q   <= S_DATA;
                    cnt_q     <= FULL_LOAD;
                    bit_idx_q <= '0;
                end
                S_DATA: if (!expire) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    shift_q[bit_idx_q] <= rxs;
                    cnt_q              <= FULL_LOAD;
                    if (bit_idx_q == 3'd7) state_q <= S_STOP;
                    else                   bit_idx_q <= bit_idx_q + 1'b1;
                end
                S_STOP: if (!expire) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    state_q <= rxs ? S_IDLE : S_BREAK;
                end
                // A held-low line must return high before another start is accepted.
                S_BREAK: if (rxs) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        push   = 1'b0;
        fe_set = 1'b0;
        if (state_q == S_STOP && expire) begin
            push   = rxs;
            fe_set = !rxs;
        end
    end

    assign ovf_set = push && fifo_full && !rd_en_i;

    prog_uart_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (push),
        .wr_data_i (shift_q),
        .pop_i     (rd_en_i),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (level_o)
    );

    assign rd_data_o = fifo_empty ? UART_EMPTY_WORD : {24'h0, head};

    // Set events take priority over a coincident clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            overflow_o  <= ovf_set | (overflow_o  & ~clr_i);
            frame_err_o <= fe_set  | (frame_err_o & ~clr_i);
        end
    end

endmodule
